// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline constants: datapath width, reset PC, bubble encoding
// and the fetch-stage state encoding.
package riscv_pkg;

    localparam int unsigned XLEN             = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] BUBBLE_INSTR     = 32'h0000_0000;

    // Fetch-stage states
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] HOLD  = 2'd2;
    localparam logic [1:0] DROP  = 2'd3;

endpackage

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, runs the imem req/ack handshake and feeds IF/ID.
// Absorbs hazard stalls (HOLD) and ID redirects, discarding in-flight data when needed (DROP).
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = riscv_pkg::RESET_PC_DEFAULT,
    parameter int unsigned XLEN     = riscv_pkg::XLEN
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            stall_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_ack_i,
    input  logic [XLEN-1:0] imem_rdata_i,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] instr_o,
    output logic            valid_o,
    output logic            flush_o
);
    import riscv_pkg::*;

    logic [1:0]      state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] req_addr_q, req_addr_d;
    logic [XLEN-1:0] buf_q, buf_d;
    logic [XLEN-1:0] redirect_tgt;
    logic [XLEN-1:0] seq_pc;

    assign redirect_tgt = {redirect_pc_i[XLEN-1:2], 2'b00};
    assign seq_pc       = req_addr_q + {{(XLEN-3){1'b0}}, 3'd4};
    assign imem_addr_o  = req_addr_q;
    assign flush_o      = redirect_i;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_addr_d = req_addr_q;
        buf_d      = buf_q;
        imem_req_o = 1'b0;
        valid_o    = 1'b0;
        instr_o    = BUBBLE_INSTR;
        pc_o       = '0;

        case (state_q)
            IDLE: begin
                state_d    = FETCH;
                req_addr_d = pc_q;
            end
            FETCH: begin
                imem_req_o = 1'b1;
                if (redirect_i) begin
                    pc_d = redirect_tgt;
                    if (imem_ack_i) begin
                        req_addr_d = redirect_tgt;
                    end else begin
                        state_d = DROP;
                    end
                end else if (imem_ack_i && !stall_i) begin
                    valid_o    = 1'b1;
                    instr_o    = imem_rdata_i;
                    pc_o       = req_addr_q;
                    pc_d       = seq_pc;
                    req_addr_d = seq_pc;
                end else if (imem_ack_i) begin
                    buf_d   = imem_rdata_i;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (redirect_i) begin
                    pc_d       = redirect_tgt;
                    req_addr_d = redirect_tgt;
                    state_d    = FETCH;
                end else begin
                    valid_o = 1'b1;
                    instr_o = buf_q;
                    pc_o    = req_addr_q;
                    // The buffered instruction is consumed in the cycle stall drops.
                    if (!stall_i) begin
                        pc_d       = seq_pc;
                        req_addr_d = seq_pc;
                        state_d    = FETCH;
                    end
                end
            end
            DROP: begin
                // Stale request must still complete; its data is thrown away.
                imem_req_o = 1'b1;
                if (redirect_i) begin
                    pc_d = redirect_tgt;
                end
                if (imem_ack_i) begin
                    req_addr_d = redirect_i ? redirect_tgt : pc_q;
                    state_d    = FETCH;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            req_addr_q <= RESET_PC;
            buf_q      <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_addr_q <= req_addr_d;
            buf_q      <= buf_d;
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: zero-wait and wait-state fetch, stall/HOLD,
// redirect into DROP and from HOLD, PC wrap, and reset aborting a request.
module tb_if_fetch_unit;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        valid;
    logic        flush;

    int unsigned n_total = 0;
    int unsigned n_pass  = 0;

    if_fetch_unit dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .stall_i      (stall),
        .redirect_i   (redirect),
        .redirect_pc_i(redirect_pc),
        .imem_req_o   (imem_req),
        .imem_addr_o  (imem_addr),
        .imem_ack_i   (imem_ack),
        .imem_rdata_i (imem_rdata),
        .pc_o         (pc),
        .instr_o      (instr),
        .valid_o      (valid),
        .flush_o      (flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_f(input logic [31:0] a);
        return a ^ 32'hC001_D00D;
    endfunction

    // Memory returns a tag of the presented address so delivered data identifies its source.
    always_comb imem_rdata = mem_f(imem_addr);

    always @(posedge clk) begin
        if (!rst) begin
            assert (!(stall && redirect))
                else $error("FAIL excl: stall and redirect both high");
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step(input logic r, input logic a, input logic s, input logic rd,
                        input logic [31:0] rp);
        @(negedge clk);
        rst         = r;
        imem_ack    = a;
        stall       = s;
        redirect    = rd;
        redirect_pc = rp;
        #1;
    endtask

    task automatic expect_out(input string tag, input logic e_req, input logic [31:0] e_addr,
                              input logic e_valid, input logic [31:0] e_pc,
                              input logic [31:0] e_instr, input logic e_flush);
        check({tag, ".req"}, {31'd0, imem_req}, {31'd0, e_req});
        if (e_req) check({tag, ".addr"}, imem_addr, e_addr);
        check({tag, ".valid"}, {31'd0, valid}, {31'd0, e_valid});
        check({tag, ".pc"}, pc, e_pc);
        check({tag, ".instr"}, instr, e_instr);
        check({tag, ".flush"}, {31'd0, flush}, {31'd0, e_flush});
    endtask

    initial begin
        rst = 1'b1; imem_ack = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;

        // Reset state, and flush follows redirect even under reset
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        expect_out("rst", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b1, 32'h40);
        check("rst_flush", {31'd0, flush}, 32'd1);

        // Zero-wait memory, back-to-back delivery
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        expect_out("zw_idle", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
            expect_out($sformatf("zw%0d", i), 1'b1, 32'(i * 4), 1'b1, 32'(i * 4),
                       mem_f(32'(i * 4)), 1'b0);
        end

        // Three wait states at 0x0
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        expect_out("ws_idle", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
            expect_out($sformatf("ws_wait%0d", i), 1'b1, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
        end
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        expect_out("ws_ack0", 1'b1, 32'h0, 1'b1, 32'h0, mem_f(32'h0), 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        expect_out("ws_ack4", 1'b1, 32'h4, 1'b1, 32'h4, mem_f(32'h4), 1'b0);

        // Stall on ack of 0x8, held for three cycles
        step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        expect_out("st_ack8", 1'b1, 32'h8, 1'b0, 32'h0, 32'h0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
            expect_out($sformatf("st_hold%0d", i), 1'b0, 32'h0, 1'b1, 32'h8, mem_f(32'h8), 1'b0);
        end
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        expect_out("st_release", 1'b0, 32'h0, 1'b1, 32'h8, mem_f(32'h8), 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        expect_out("st_nextC", 1'b1, 32'hC, 1'b1, 32'hC, mem_f(32'hC), 1'b0);

        // Redirect while waiting on 0x10 -> DROP; second redirect wins
        step(1'b0, 1'b0, 1'b0, 1'b1, 32'h100);
        expect_out("dr_redir", 1'b1, 32'h10, 1'b0, 32'h0, 32'h0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1, 32'h300);
        expect_out("dr_redir2", 1'b1, 32'h10, 1'b0, 32'h0, 32'h0, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        expect_out("dr_discard", 1'b1, 32'h10, 1'b0, 32'h0, 32'h0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        expect_out("dr_target", 1'b1, 32'h300, 1'b1, 32'h300, mem_f(32'h300), 1'b0);

        // Redirect from HOLD to a misaligned target
        step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        expect_out("hr_stall", 1'b1, 32'h304, 1'b0, 32'h0, 32'h0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 32'h203);
        expect_out("hr_redir", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        expect_out("hr_target", 1'b1, 32'h200, 1'b1, 32'h200, mem_f(32'h200), 1'b0);

        // Redirect with ack stays in FETCH; then PC wrap at the top of memory
        step(1'b0, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF);
        expect_out("wr_redir", 1'b1, 32'h204, 1'b0, 32'h0, 32'h0, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        expect_out("wr_top", 1'b1, 32'hFFFF_FFFC, 1'b1, 32'hFFFF_FFFC, mem_f(32'hFFFF_FFFC), 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b1, 32'h24);
        expect_out("wr_wrap", 1'b1, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1);

        // Reset aborts the request at 0x24; the late ack is ignored
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        expect_out("ra_wait", 1'b1, 32'h24, 1'b0, 32'h0, 32'h0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        expect_out("ra_late", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        expect_out("ra_restart", 1'b1, 32'h0, 1'b1, 32'h0, mem_f(32'h0), 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
